// File: rtl/lsu_dmem_port_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, default memory size.
// The optional bounds check in lsu_dmem_port is enabled by defining LSU_BOUNDS_CHECK_EN.
package lsu_dmem_port_pkg;

   localparam int unsigned MemBytesDmem = 1024;

   localparam logic [1:0] LsuSizeByte = 2'b00;
   localparam logic [1:0] LsuSizeHalf = 2'b01;
   localparam logic [1:0] LsuSizeWord = 2'b10;

   typedef enum logic [1:0] {
      StIdle     = 2'b00,
      StLdWait   = 2'b01,
      StRmwMerge = 2'b10
   } lsu_state_e;

   // Illegal size or an address not aligned to the access size.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         LsuSizeByte: bad = 1'b0;
         LsuSizeHalf: bad = addr_lo[0];
         LsuSizeWord: bad = (addr_lo != 2'b00);
         default:     bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane logic for the LSU: extracts and extends load data from a memory word, and merges
// sub-word store data into a memory word.
module lsu_lane_align
   import lsu_dmem_port_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merged_o
);

   logic [4:0]  shamt;
   logic [31:0] shifted;

   assign shamt   = {addr_lo_i, 3'b000};
   assign shifted = word_i >> shamt;

   always_comb begin
      load_o   = shifted;
      merged_o = wdata_i;
      case (size_i)
         LsuSizeByte: begin
            load_o   = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
            merged_o = (word_i & ~(32'h0000_00ff << shamt)) | ({24'h0, wdata_i[7:0]} << shamt);
         end
         LsuSizeHalf: begin
            load_o   = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            merged_o = (word_i & ~(32'h0000_ffff << shamt)) | ({16'h0, wdata_i[15:0]} << shamt);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_dmem_port.sv
// Load/store unit front end to dmem: alignment/size checks, load extend, sub-word RMW stores.
// Define LSU_BOUNDS_CHECK_EN to reject accesses whose aligned word lies outside MEM_BYTES.
module lsu_dmem_port
   import lsu_dmem_port_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MemBytesDmem
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

`ifdef LSU_BOUNDS_CHECK_EN
   localparam logic BoundsEn = 1'b1;
`else
   localparam logic BoundsEn = 1'b0;
`endif

   lsu_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        unsigned_q, unsigned_d;
   logic [31:0] wdata_q, wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;

   logic [31:0] req_addr_al;
   logic        accept, req_oob, req_err, req_word_store;
   logic [31:0] lane_load, lane_merged;

   assign req_addr_al    = {req_addr_i[31:2], 2'b00};
   assign accept         = req_valid_i && (state_q == StIdle);
   assign req_oob        = (req_addr_al > (MEM_BYTES - 32'd4));
   assign req_err        = misaligned(req_size_i, req_addr_i[1:0]) || (BoundsEn && req_oob);
   assign req_word_store = req_we_i && (req_size_i == LsuSizeWord);

   lsu_lane_align u_lane_align (
      .word_i     (mem_rdata_i),
      .addr_lo_i  (addr_q[1:0]),
      .size_i     (size_q),
      .unsigned_i (unsigned_q),
      .wdata_i    (wdata_q),
      .load_o     (lane_load),
      .merged_o   (lane_merged)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (accept && !req_err && !req_word_store) begin
               state_d = req_we_i ? StRmwMerge : StLdWait;
            end
         end
         StLdWait, StRmwMerge: state_d = StIdle;
         default:              state_d = StIdle;
      endcase
   end

   always_comb begin
      addr_d       = addr_q;
      size_d       = size_q;
      unsigned_d   = unsigned_q;
      wdata_d      = wdata_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               addr_d     = req_addr_i;
               size_d     = req_size_i;
               unsigned_d = req_unsigned_i;
               wdata_d    = req_wdata_i;
               // Errors and word stores complete without leaving IDLE.
               if (req_err || req_word_store) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = req_err;
               end
            end
         end
         StLdWait: begin
            resp_valid_d = 1'b1;
            resp_rdata_d = lane_load;
         end
         StRmwMerge: resp_valid_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q       <= '0;
         size_q       <= '0;
         unsigned_q   <= 1'b0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         addr_q       <= addr_d;
         size_q       <= size_d;
         unsigned_q   <= unsigned_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   always_comb begin
      req_ready_o = (state_q == StIdle);
      mem_we_o    = 1'b0;
      mem_addr_o  = {addr_q[31:2], 2'b00};
      mem_wdata_o = '0;
      case (state_q)
         StIdle: begin
            mem_addr_o  = req_addr_al;
            mem_wdata_o = req_wdata_i;
            mem_we_o    = accept && !req_err && req_word_store;
         end
         StRmwMerge: begin
            mem_we_o    = 1'b1;
            mem_wdata_o = lane_merged;
         end
         default: ;
      endcase
      // Write enable must fall as soon as reset rises, not at the next edge.
      if (rst_i) begin
         mem_we_o = 1'b0;
      end
   end

   assign resp_valid_o = resp_valid_q;
   assign resp_err_o   = resp_err_q;
   assign resp_rdata_o = resp_rdata_q;

endmodule
